// File: rtl/wb_mem_arbiter_pkg.sv
// wb_mem_arbiter_pkg: FSM state encoding and master ids shared by the arbiter files.
package wb_mem_arbiter_pkg;
    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_GNT_I = 2'd1;
    localparam logic [1:0] ARB_GNT_D = 2'd2;
    localparam logic ARB_M_I = 1'b0;
    localparam logic ARB_M_D = 1'b1;
endpackage

// File: rtl/wb_arb_pick.sv
// wb_arb_pick: two-master grant decision; ARB_DATA_PRIORITY_EN makes data win ties, else ties alternate.
module wb_arb_pick
    import wb_mem_arbiter_pkg::*;
(
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic last_gnt_i,
    output logic gnt_i_o,
    output logic gnt_d_o
);
    logic tie_d;
`ifdef ARB_DATA_PRIORITY_EN
    assign tie_d = 1'b1;
`else
    assign tie_d = last_gnt_i == ARB_M_I;
`endif
    assign gnt_d_o = d_req_i & (~i_req_i | tie_d);
    assign gnt_i_o = i_req_i & ~gnt_d_o;
endmodule

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: iwb/dwb Wishbone arbiter onto one memory port; ARB_DATA_PRIORITY_EN selects data-priority ties.
module wb_mem_arbiter
    import wb_mem_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   iwb_adr_i,
    input  logic            iwb_cyc_i,
    input  logic            iwb_stb_i,
    output logic [DW-1:0]   iwb_dat_o,
    output logic            iwb_ack_o,
    input  logic [AW-1:0]   dwb_adr_i,
    input  logic [DW-1:0]   dwb_dat_i,
    input  logic            dwb_we_i,
    input  logic [DW/8-1:0] dwb_sel_i,
    input  logic            dwb_cyc_i,
    input  logic            dwb_stb_i,
    output logic [DW-1:0]   dwb_dat_o,
    output logic            dwb_ack_o,
    output logic            dwb_err_o,
    output logic [AW-1:0]   mem_adr_o,
    output logic [DW-1:0]   mem_dat_o,
    output logic            mem_we_o,
    output logic [DW/8-1:0] mem_sel_o,
    output logic            mem_cyc_o,
    output logic            mem_stb_o,
    input  logic [DW-1:0]   mem_dat_i,
    input  logic            mem_ack_i,
    input  logic            mem_err_i,
    output logic            ibus_err_o
);
    logic [1:0] state_q, state_d;
    logic last_gnt_q, last_gnt_d, ibus_err_q, ibus_err_d;
    logic pick_i, pick_d, gnt_i, gnt_d, done;
    wb_arb_pick u_pick (
        .i_req_i   (iwb_cyc_i & iwb_stb_i),
        .d_req_i   (dwb_cyc_i & dwb_stb_i),
        .last_gnt_i(last_gnt_q),
        .gnt_i_o   (pick_i),
        .gnt_d_o   (pick_d)
    );
    assign gnt_i = state_q == ARB_GNT_I;
    assign gnt_d = state_q == ARB_GNT_D;
    assign done  = (gnt_i | gnt_d) & (mem_ack_i | mem_err_i);
    // a grant ends on completion or when its owner abandons the cycle
    always_comb begin
        state_d    = state_q;
        last_gnt_d = done ? (gnt_d ? ARB_M_D : ARB_M_I) : last_gnt_q;
        ibus_err_d = ibus_err_q | (gnt_i & mem_err_i);
        if (state_q == ARB_IDLE)
            state_d = pick_d ? ARB_GNT_D : pick_i ? ARB_GNT_I : ARB_IDLE;
        else if (done || !(gnt_i ? iwb_cyc_i : gnt_d & dwb_cyc_i))
            state_d = ARB_IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            last_gnt_q <= ARB_M_I;
            ibus_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            ibus_err_q <= ibus_err_d;
        end
    end
    assign mem_adr_o  = gnt_i ? iwb_adr_i : gnt_d ? dwb_adr_i : '0;
    assign mem_dat_o  = gnt_d ? dwb_dat_i : '0;
    assign mem_we_o   = gnt_d & dwb_we_i;
    assign mem_sel_o  = gnt_i ? '1 : gnt_d ? dwb_sel_i : '0;
    assign mem_cyc_o  = (gnt_i & iwb_cyc_i) | (gnt_d & dwb_cyc_i);
    assign mem_stb_o  = (gnt_i & iwb_stb_i) | (gnt_d & dwb_stb_i);
    assign iwb_dat_o  = gnt_i ? mem_dat_i : '0;
    assign iwb_ack_o  = gnt_i & (mem_ack_i | mem_err_i);
    assign dwb_dat_o  = gnt_d ? mem_dat_i : '0;
    assign dwb_ack_o  = gnt_d & mem_ack_i & ~mem_err_i;
    assign dwb_err_o  = gnt_d & mem_err_i;
    assign ibus_err_o = ibus_err_q;
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: table vectors, corner sequences and random traffic against a reference model.
module tb_wb_mem_arbiter;
`ifdef ARB_DATA_PRIORITY_EN
    localparam bit DATA_PRI = 1'b1;
`else
    localparam bit DATA_PRI = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] i_adr, d_adr, d_dat, m_dat;
    logic i_cyc, i_stb, d_cyc, d_stb, d_we, m_ack, m_err;
    logic [3:0] d_sel;
    logic [31:0] iwb_dat_o, dwb_dat_o, mem_adr_o, mem_dat_o;
    logic iwb_ack_o, dwb_ack_o, dwb_err_o, mem_we_o, mem_cyc_o, mem_stb_o, ibus_err_o;
    logic [3:0] mem_sel_o;
    logic [138:0] dut_out;
    int errors = 0, checks = 0;
    int own, last;
    bit ierr;

    always #5 clk = ~clk;

    wb_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .iwb_adr_i(i_adr), .iwb_cyc_i(i_cyc), .iwb_stb_i(i_stb),
        .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o),
        .dwb_adr_i(d_adr), .dwb_dat_i(d_dat), .dwb_we_i(d_we), .dwb_sel_i(d_sel),
        .dwb_cyc_i(d_cyc), .dwb_stb_i(d_stb),
        .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o),
        .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
        .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o),
        .mem_dat_i(m_dat), .mem_ack_i(m_ack), .mem_err_i(m_err),
        .ibus_err_o(ibus_err_o)
    );

    assign dut_out = {mem_adr_o, mem_dat_o, mem_we_o, mem_sel_o, mem_cyc_o, mem_stb_o,
                      iwb_dat_o, iwb_ack_o, dwb_dat_o, dwb_ack_o, dwb_err_o, ibus_err_o};

    // own: 0 nobody, 1 instruction, 2 data; last: 1 instruction, 2 data
    function automatic logic [138:0] model_out();
        logic [31:0] adr = 0, mdo = 0, idat = 0, ddat = 0;
        logic [3:0] sel = 0;
        logic we = 0, cyc = 0, stb = 0, iack = 0, dack = 0, derr = 0;
        if (own == 1) begin
            adr = i_adr; sel = 4'hF; cyc = i_cyc; stb = i_stb;
            idat = m_dat; iack = m_ack | m_err;
        end
        if (own == 2) begin
            adr = d_adr; mdo = d_dat; we = d_we; sel = d_sel; cyc = d_cyc; stb = d_stb;
            ddat = m_dat; dack = m_ack & ~m_err; derr = m_err;
        end
        return {adr, mdo, we, sel, cyc, stb, idat, iack, ddat, dack, derr, ierr};
    endfunction

    task automatic model_clock();
        bit ir = i_cyc & i_stb;
        bit dr = d_cyc & d_stb;
        if (own == 1 && m_err) ierr = 1;
        if (own == 0) begin
            if (ir && dr) own = (DATA_PRI || last == 1) ? 2 : 1;
            else own = dr ? 2 : ir ? 1 : 0;
        end else if (m_ack || m_err) begin
            last = own;
            own = 0;
        end else if ((own == 1 && !i_cyc) || (own == 2 && !d_cyc)) own = 0;
    endtask

    task automatic clear_inputs();
        i_adr = 0; i_cyc = 0; i_stb = 0;
        d_adr = 0; d_dat = 0; d_we = 0; d_sel = 0; d_cyc = 0; d_stb = 0;
        m_dat = 0; m_ack = 0; m_err = 0;
    endtask

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // called just after a falling edge with inputs set; checks, advances model, returns at next falling edge
    task automatic tick(string name);
        logic [138:0] exp;
        #1;
        exp = model_out();
        checks++;
        if (dut_out !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, dut_out, exp);
        end
        model_clock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        #1;
        checks++;
        if (dut_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", dut_out);
        end
        own = 0; last = 1; ierr = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic ic; logic [31:0] ia;
        logic dc, dw; logic [31:0] da, dd; logic [3:0] ds;
        logic ma, me; logic [31:0] md;
        logic [31:0] e_adr, e_mdo; logic e_we; logic [3:0] e_sel; logic e_cyc;
        logic [31:0] e_idat; logic e_iack, e_dack, e_derr, e_ierr;
    } vec_t;
    vec_t tbl [13];

    initial begin
        logic [105:0] got, exp;
        int d_xfers, i_acks, first_i;
        tbl[0]  = '{1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 32'h13,  32'h100, 0, 0, 4'hF, 1, 32'h13, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 1, 32'h1002, 32'hBEEF0000, 4'hC, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 1, 1, 32'h1002, 32'hBEEF0000, 4'hC, 0, 0, 0,
                    32'h1002, 32'hBEEF0000, 1, 4'hC, 1, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 1, 1, 32'h1002, 32'hBEEF0000, 4'hC, 1, 0, 32'h12345678,
                    32'h1002, 32'hBEEF0000, 1, 4'hC, 1, 0, 0, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 32'h55,  32'h200, 0, 0, 4'hF, 1, 32'h55, 1, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[10] = '{0, 0, 1, 0, 32'h300, 0, 4'hF, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[11] = '{0, 0, 1, 0, 32'h300, 0, 4'hF, 0, 1, 0,    32'h300, 0, 0, 4'hF, 1, 0, 0, 0, 1, 1};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

        do_reset();
        for (int k = 0; k < 13; k++) begin
            i_cyc = tbl[k].ic; i_stb = tbl[k].ic; i_adr = tbl[k].ia;
            d_cyc = tbl[k].dc; d_stb = tbl[k].dc; d_we = tbl[k].dw;
            d_adr = tbl[k].da; d_dat = tbl[k].dd; d_sel = tbl[k].ds;
            m_ack = tbl[k].ma; m_err = tbl[k].me; m_dat = tbl[k].md;
            #1;
            got = {mem_adr_o, mem_dat_o, mem_we_o, mem_sel_o, mem_cyc_o, iwb_dat_o,
                   iwb_ack_o, dwb_ack_o, dwb_err_o, ibus_err_o};
            exp = {tbl[k].e_adr, tbl[k].e_mdo, tbl[k].e_we, tbl[k].e_sel, tbl[k].e_cyc,
                   tbl[k].e_idat, tbl[k].e_iack, tbl[k].e_dack, tbl[k].e_derr, tbl[k].e_ierr};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL vec%0d: got %h expected %h", k, got, exp);
            end
            tick($sformatf("vec%0d_model", k));
        end

        // ties from reset: data first, then alternation or data priority
        do_reset();
        i_cyc = 1; i_stb = 1; i_adr = 32'h400;
        d_cyc = 1; d_stb = 1; d_adr = 32'h500; d_sel = 4'hF;
        m_ack = 1; m_dat = 32'hA5A5A5A5;
        tick("tie_idle0");
        #1 chk("tie_first", {32'd0, mem_adr_o}, {32'd0, 32'h500});
        tick("tie_g0");
        tick("tie_idle1");
        #1 chk("tie_second", {32'd0, mem_adr_o}, {32'd0, DATA_PRI ? 32'h500 : 32'h400});
        tick("tie_g1");
        tick("tie_idle2");
        #1 chk("tie_third", {32'd0, mem_adr_o}, {32'd0, 32'h500});
        tick("tie_g2");
        clear_inputs();
        tick("tie_done");

        // continuous data traffic with a pending fetch
        do_reset();
        i_cyc = 1; i_stb = 1; i_adr = 32'h600;
        d_cyc = 1; d_stb = 1; d_adr = 32'h700; d_sel = 4'hF; m_ack = 1;
        d_xfers = 0; i_acks = 0; first_i = -1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (iwb_ack_o) begin
                i_acks++;
                if (first_i < 0) first_i = d_xfers;
            end
            if (dwb_ack_o) d_xfers++;
            tick("starve_model");
        end
        if (DATA_PRI) chk("starve_i_acks", 64'(i_acks), 64'd0);
        else chk("starve_i_within2", 64'(first_i >= 0 && first_i <= 2), 64'd1);
        d_cyc = 0; d_stb = 0;
        i_acks = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (iwb_ack_o) i_acks++;
            tick("starve_release");
        end
        chk("starve_i_after_d", 64'(i_acks > 0), 64'd1);
        clear_inputs();
        tick("starve_done");

        // reset mid-grant with memory stalled
        do_reset();
        d_cyc = 1; d_stb = 1; d_we = 1; d_adr = 32'h800; d_dat = 32'h11223344; d_sel = 4'hF;
        m_dat = 32'hDEADBEEF;
        tick("rst_req");
        tick("rst_stall");
        #1 chk("rst_pre_cyc", {63'd0, mem_cyc_o}, 64'd1);
        rst = 1'b1;
        #1;
        checks++;
        if (dut_out !== '0) begin
            errors++;
            $display("FAIL rst_midgrant: got %h expected 0", dut_out);
        end
        clear_inputs();
        own = 0; last = 1; ierr = 0;
        @(negedge clk);
        rst = 1'b0;
        i_cyc = 1; i_stb = 1; i_adr = 32'h900;
        tick("rst_fetch_req");
        m_ack = 1; m_dat = 32'h13;
        #1 chk("rst_fetch_ack", {31'd0, iwb_ack_o, iwb_dat_o}, {31'd0, 1'b1, 32'h13});
        tick("rst_fetch_g");
        clear_inputs();
        tick("rst_fetch_idle");

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 500; c++) begin
            i_cyc = ($urandom % 4) != 0;
            i_stb = ($urandom % 4) != 0;
            i_adr = $urandom;
            d_cyc = ($urandom % 3) != 0;
            d_stb = ($urandom % 4) != 0;
            d_we = $urandom % 2;
            d_adr = $urandom; d_dat = $urandom; d_sel = 4'($urandom);
            m_ack = ($urandom % 3) == 0;
            m_err = ($urandom % 16) == 0;
            m_dat = $urandom;
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
